// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write-port arbiter: state encoding, owner ids
// and default burst sizing.
package fifo_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] OWN_A = 2'b01;
  localparam logic [1:0] OWN_B = 2'b10;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  localparam int MAX_BURST_DEF = 4;
  localparam int BURST_W_DEF   = 3;

endpackage

// File: rtl/fifo_write_arbiter_burst_counter.sv
// Burst length counter: synchronous clear (wins over enable), count enable and
// a terminal-count flag raised while the current word would be the burst's last.
module burst_counter
  import fifo_arb_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BURST_W   = BURST_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [BURST_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == BURST_W'(MAX_BURST - 1));

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port between
// producers A and B. Define FIFO_ARB_PFF_THROTTLE_EN to cap bursts at one word while PFF=1.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int BURST_W   = BURST_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_A,
  input  logic [DATA_W-1:0] DIN_A,
  output logic              GNT_A,
  input  logic              REQ_B,
  input  logic [DATA_W-1:0] DIN_B,
  output logic              GNT_B,
  input  logic              FF,
  input  logic              PFF,
  output logic              WE,
  output logic [DATA_W-1:0] DOUT,
  output logic [1:0]        OWNER
);

  logic [1:0] state, state_nxt;
  logic       last, last_nxt;
  logic       tc, limit, last_word, cnt_clr;

  assign GNT_A = (state == OWN_A) & ~FF;
  assign GNT_B = (state == OWN_B) & ~FF;
  assign WE    = ((GNT_A & REQ_A) | (GNT_B & REQ_B)) & ~RESET;
  assign DOUT  = (state == OWN_B) ? DIN_B : DIN_A;
  assign OWNER = state;

`ifdef FIFO_ARB_PFF_THROTTLE_EN
  // Near full every accepted word ends the burst, forcing strict alternation.
  assign limit = tc | PFF;
`else
  logic unused_pff;
  assign unused_pff = PFF;
  assign limit      = tc;
`endif

  assign last_word = WE & limit;

  burst_counter #(
    .MAX_BURST(MAX_BURST),
    .BURST_W  (BURST_W)
  ) u_burst (
    .clk(CLK),
    .rst(RESET),
    .clr(cnt_clr),
    .en (WE),
    .tc (tc)
  );

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (REQ_A && (!REQ_B || last == OWNER_B)) state_nxt = OWN_A;
        else if (REQ_B)                           state_nxt = OWN_B;
      end
      OWN_A: begin
        if (!REQ_A || last_word) begin
          cnt_clr  = 1'b1;
          last_nxt = OWNER_A;
          if (REQ_B)      state_nxt = OWN_B;
          else if (REQ_A) state_nxt = OWN_A;
          else            state_nxt = IDLE;
        end
      end
      OWN_B: begin
        if (!REQ_B || last_word) begin
          cnt_clr  = 1'b1;
          last_nxt = OWNER_B;
          if (REQ_A)      state_nxt = OWN_A;
          else if (REQ_B) state_nxt = OWN_B;
          else            state_nxt = IDLE;
        end
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      last  <= OWNER_B;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle vector table plus scoreboarded
// producer streams against a simple 16-deep FIFO fill model.
module tb_fifo_write_arbiter;

  logic       CLK, RESET, REQ_A, REQ_B, FF, PFF;
  logic [7:0] DIN_A, DIN_B, DOUT;
  logic       GNT_A, GNT_B, WE;
  logic [1:0] OWNER;

  int tests = 0;
  int fails = 0;
  int fill  = 0;
  logic [7:0] qa[$], qb[$], expq[$];

  typedef struct {
    logic rst, ra, rb, ff, pff;
    logic [7:0] da, db;
    logic ga, gb, we;
    logic [1:0] own;
    logic [7:0] dout;
  } vec_t;

  vec_t vq[$];

  fifo_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_A(REQ_A), .DIN_A(DIN_A), .GNT_A(GNT_A),
    .REQ_B(REQ_B), .DIN_B(DIN_B), .GNT_B(GNT_B),
    .FF(FF), .PFF(PFF), .WE(WE), .DOUT(DOUT), .OWNER(OWNER)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, ra, rb, ff, input logic [7:0] da, db,
                              input logic ga, gb, we, input logic [1:0] own,
                              input logic [7:0] dout);
    vec_t v;
    v.rst = rst; v.ra = ra; v.rb = rb; v.ff = ff; v.pff = 1'b0;
    v.da = da; v.db = db; v.ga = ga; v.gb = gb; v.we = we; v.own = own; v.dout = dout;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge CLK);
    RESET = v.rst; REQ_A = v.ra; REQ_B = v.rb; FF = v.ff; PFF = v.pff;
    DIN_A = v.da; DIN_B = v.db;
    #1;
    chk($sformatf("vec%0d {ga,gb,we,own,dout}", idx),
        {19'd0, GNT_A, GNT_B, WE, OWNER, DOUT},
        {19'd0, v.ga, v.gb, v.we, v.own, v.dout});
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1; REQ_A = 0; REQ_B = 0; FF = 0; PFF = 0;
    @(negedge CLK);
    RESET = 0;
    fill = 0;
    qa.delete(); qb.delete(); expq.delete();
  endtask

  // Producers present the head of their queue; FF tracks a 16-deep FIFO model.
  task automatic run_stream(input string name, input bit pff_force, input bit a_only,
                            input int tail);
    int   cyc = 0;
    int   post = 0;
    bit   started = 0;
    logic we_s, ga_s;
    logic [7:0] e;
    while (1) begin
      @(negedge CLK);
      REQ_A = (qa.size() > 0);
      DIN_A = (qa.size() > 0) ? qa[0] : 8'h00;
      REQ_B = (qb.size() > 0);
      DIN_B = (qb.size() > 0) ? qb[0] : 8'h00;
      FF    = (fill >= 16);
      PFF   = pff_force;
      #1;
      if (FF) chk({name, " we_while_full"}, {31'd0, WE}, 32'd0);
      if (started && expq.size() > 0) chk({name, " no_bubble"}, {31'd0, WE}, 32'd1);
      if (a_only && started && expq.size() > 0) chk({name, " owner"}, {30'd0, OWNER}, 32'd1);
      if (WE) begin
        started = 1;
        if (expq.size() == 0) begin
          chk({name, " unexpected_write"}, {24'd0, DOUT}, 32'hFFFF_FFFF);
        end else begin
          e = expq.pop_front();
          chk({name, " dout"}, {24'd0, DOUT}, {24'd0, e});
        end
      end
      we_s = WE;
      ga_s = GNT_A;
      @(posedge CLK);
      if (we_s) begin
        fill++;
        if (ga_s) void'(qa.pop_front());
        else      void'(qb.pop_front());
      end
      cyc++;
      if (expq.size() == 0) post++;
      if (post >= tail) break;
      if (cyc >= 300) begin
        chk({name, " timeout_pending_words"}, expq.size(), 32'd0);
        break;
      end
    end
    @(negedge CLK);
    REQ_A = 0; REQ_B = 0; FF = 0; PFF = 0;
  endtask

  initial begin
    RESET = 1; REQ_A = 1; REQ_B = 1; FF = 0; PFF = 0; DIN_A = 8'hA0; DIN_B = 8'hB0;

    // rst ra rb ff   da     db    | ga gb we own    dout
    vq.push_back(mk(1,1,1,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB0, 1,0,1,2'b01,8'hA0));
    vq.push_back(mk(0,1,1,0, 8'hA1,8'hB0, 1,0,1,2'b01,8'hA1));
    vq.push_back(mk(0,0,1,0, 8'hA0,8'hB0, 1,0,0,2'b01,8'hA0));
    vq.push_back(mk(0,0,1,0, 8'hA0,8'hB0, 0,1,1,2'b10,8'hB0));
    vq.push_back(mk(0,0,1,1, 8'hA0,8'hB0, 0,0,0,2'b10,8'hB0));
    vq.push_back(mk(0,0,0,1, 8'hA0,8'hB0, 0,0,0,2'b10,8'hB0));
    vq.push_back(mk(0,0,0,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,0,1,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB0, 0,1,1,2'b10,8'hB0));
    vq.push_back(mk(0,1,0,0, 8'hA0,8'hB0, 0,1,0,2'b10,8'hB0));
    vq.push_back(mk(1,1,0,0, 8'hA0,8'hB0, 1,0,0,2'b01,8'hA0));
    vq.push_back(mk(0,1,0,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,0,0,0, 8'hA0,8'hB0, 1,0,0,2'b01,8'hA0));
    vq.push_back(mk(0,0,0,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB0, 0,1,1,2'b10,8'hB0));
    // B mid-burst stalled by FF, finishes its burst, then hands over to A
    vq.push_back(mk(1,0,0,0, 8'hA0,8'hB0, 0,1,0,2'b10,8'hB0));
    vq.push_back(mk(0,0,1,0, 8'hA0,8'hB0, 0,0,0,2'b00,8'hA0));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB0, 0,1,1,2'b10,8'hB0));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB1, 0,1,1,2'b10,8'hB1));
    vq.push_back(mk(0,1,1,1, 8'hA0,8'hB2, 0,0,0,2'b10,8'hB2));
    vq.push_back(mk(0,1,1,1, 8'hA0,8'hB2, 0,0,0,2'b10,8'hB2));
    vq.push_back(mk(0,1,1,1, 8'hA0,8'hB2, 0,0,0,2'b10,8'hB2));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB2, 0,1,1,2'b10,8'hB2));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB3, 0,1,1,2'b10,8'hB3));
    vq.push_back(mk(0,1,1,0, 8'hA0,8'hB4, 1,0,1,2'b01,8'hA0));
    vq.push_back(mk(0,0,0,0, 8'hA0,8'hB4, 1,0,0,2'b01,8'hA0));

    @(negedge CLK);
    #1;
    chk("reset_cycle1 {ga,gb,we}", {29'd0, GNT_A, GNT_B, WE}, 32'd0);
    for (int i = 0; i < vq.size(); i++) apply_vec(vq[i], i);

    // A alone: two back-to-back 4-word bursts
    do_reset();
    for (int i = 0; i < 8; i++) begin
      qa.push_back(8'h10 + 8'(i));
      expq.push_back(8'h10 + 8'(i));
    end
    run_stream("solo_a", 1'b0, 1'b1, 2);

    // Both requesting until the FIFO fills after 16 words
    do_reset();
    for (int i = 0; i < 12; i++) begin
      qa.push_back(8'h20 + 8'(i));
      qb.push_back(8'h40 + 8'(i));
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (k % 2 == 0) expq.push_back(8'h20 + 8'((k / 2) * 4 + i));
        else            expq.push_back(8'h40 + 8'((k / 2) * 4 + i));
      end
    end
    run_stream("both_fill", 1'b0, 1'b0, 5);
    chk("both_fill remaining_a", qa.size(), 32'd4);
    chk("both_fill remaining_b", qb.size(), 32'd4);

    // PFF held high with both requesting
    do_reset();
    for (int i = 0; i < 8; i++) begin
      qa.push_back(8'h60 + 8'(i));
      qb.push_back(8'h70 + 8'(i));
    end
`ifdef FIFO_ARB_PFF_THROTTLE_EN
    for (int i = 0; i < 8; i++) begin
      expq.push_back(8'h60 + 8'(i));
      expq.push_back(8'h70 + 8'(i));
    end
`else
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (k % 2 == 0) expq.push_back(8'h60 + 8'((k / 2) * 4 + i));
        else            expq.push_back(8'h70 + 8'((k / 2) * 4 + i));
      end
    end
`endif
    run_stream("pff", 1'b1, 1'b0, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
